// File: rtl/pc_redirect_unit_pkg.sv
// Shared next-PC select encodings and default fetch addresses for the PC redirect unit.
package pc_redirect_unit_pkg;

  typedef enum logic [1:0] {
    Sequence = 2'b00,
    Branch   = 2'b01,
    Jump     = 2'b10,
    JumpReg  = 2'b11
  } npc_sel_e;

  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_4180;

endpackage

// File: rtl/pc_redirect_unit_target_calc.sv
// Combinational redirect target mux: branch offset add, jump concatenation, register pass-through.
module pc_target_calc
  import pc_redirect_unit_pkg::*;
(
  input  logic [1:0]  sel_i,
  input  logic [31:0] pc_plus4_i,
  input  logic [15:0] imm16_i,
  input  logic [25:0] index26_i,
  input  logic [31:0] rs_val_i,
  output logic [31:0] target_o,
  output logic        redirect_o
);

  always_comb begin
    target_o   = pc_plus4_i;
    redirect_o = 1'b0;
    case (sel_i)
      Branch: begin
        target_o   = pc_plus4_i + {{14{imm16_i[15]}}, imm16_i, 2'b00};
        redirect_o = 1'b1;
      end
      Jump: begin
        target_o   = {pc_plus4_i[31:28], index26_i, 2'b00};
        redirect_o = 1'b1;
      end
      JumpReg: begin
        target_o   = rs_val_i;
        redirect_o = 1'b1;
      end
      // Sequence and any unresolved select value fall through as no redirect.
      default: begin
        target_o   = pc_plus4_i;
        redirect_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC register with redirect buffering across IF stalls and IF/ID flush generation.
// Optional PC_ALIGN_CHECK_EN: misaligned redirect targets vector to EXC_VECTOR and pulse addr_err.
module pc_redirect_unit
  import pc_redirect_unit_pkg::*;
#(
`ifdef PC_ALIGN_CHECK_EN
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
`endif
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic [1:0]  branch_Or_Jump,
  input  logic [31:0] pc_plus4_id,
  input  logic [15:0] imm16_id,
  input  logic [25:0] index26_id,
  input  logic [31:0] rs_val_id,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        flush_if_id,
  output logic        redirect_pending,
  output logic        addr_err
);

  logic [31:0] pc_q, pc_d;
  logic        pending_valid_q, pending_valid_d;
  logic [31:0] pending_target_q, pending_target_d;
  logic [31:0] live_target, sel_target, load_target;
  logic        live_redirect, redirect_go;

  pc_target_calc u_target_calc (
    .sel_i      (branch_Or_Jump),
    .pc_plus4_i (pc_plus4_id),
    .imm16_i    (imm16_id),
    .index26_i  (index26_id),
    .rs_val_i   (rs_val_id),
    .target_o   (live_target),
    .redirect_o (live_redirect)
  );

  // A buffered redirect is older than whatever ID presents now, so it wins.
  assign sel_target  = pending_valid_q ? pending_target_q : live_target;
  assign redirect_go = !stall_i && (pending_valid_q || live_redirect);

`ifdef PC_ALIGN_CHECK_EN
  logic addr_err_q;
  logic misaligned;

  assign misaligned  = (sel_target[1:0] != 2'b00);
  assign load_target = misaligned ? EXC_VECTOR : sel_target;

  always_ff @(posedge clk) begin
    if (rst) addr_err_q <= 1'b0;
    else     addr_err_q <= redirect_go && misaligned;
  end

  assign addr_err = addr_err_q;
`else
  assign load_target = sel_target;
  assign addr_err    = 1'b0;
`endif

  always_comb begin
    pc_d             = pc_q + 32'd4;
    pending_valid_d  = pending_valid_q;
    pending_target_d = pending_target_q;
    if (stall_i) begin
      pc_d = pc_q;
      // ID is frozen while stalled, so only the first redirect seen is captured.
      if (live_redirect && !pending_valid_q) begin
        pending_valid_d  = 1'b1;
        pending_target_d = live_target;
      end
    end else begin
      pending_valid_d = 1'b0;
      if (redirect_go) pc_d = load_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q             <= RESET_PC;
      pending_valid_q  <= 1'b0;
      pending_target_q <= 32'h0;
    end else begin
      pc_q             <= pc_d;
      pending_valid_q  <= pending_valid_d;
      pending_target_q <= pending_target_d;
    end
  end

  assign pc               = pc_q;
  assign pc_plus4         = pc_q + 32'd4;
  assign flush_if_id      = !rst && redirect_go;
  assign redirect_pending = pending_valid_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Table-driven self-checking bench for pc_redirect_unit with an expected-output queue.
module tb_pc_redirect_unit;

`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  localparam logic [1:0] SEQ = 2'b00, BR = 2'b01, JMP = 2'b10, JR = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic [1:0]  branch_Or_Jump;
  logic [31:0] pc_plus4_id;
  logic [15:0] imm16_id;
  logic [25:0] index26_id;
  logic [31:0] rs_val_id;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        flush_if_id;
  logic        redirect_pending;
  logic        addr_err;

  pc_redirect_unit dut (
    .clk              (clk),
    .rst              (rst),
    .stall_i          (stall_i),
    .branch_Or_Jump   (branch_Or_Jump),
    .pc_plus4_id      (pc_plus4_id),
    .imm16_id         (imm16_id),
    .index26_id       (index26_id),
    .rs_val_id        (rs_val_id),
    .pc               (pc),
    .pc_plus4         (pc_plus4),
    .flush_if_id      (flush_if_id),
    .redirect_pending (redirect_pending),
    .addr_err         (addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic [1:0]  sel;
    logic [31:0] p4;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] rs;
    logic [31:0] e_pc;
    logic        e_flush;
    logic        e_pend;
    logic        e_err;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic        flush;
    logic        pend;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(logic r, logic s, logic [1:0] sel, logic [31:0] p4, logic [15:0] imm,
                              logic [25:0] idx, logic [31:0] rs, logic [31:0] e_pc,
                              logic e_flush, logic e_pend, logic e_err);
    vec_t v;
    v.rst = r; v.stall = s; v.sel = sel; v.p4 = p4; v.imm = imm; v.idx = idx; v.rs = rs;
    v.e_pc = e_pc; v.e_flush = e_flush; v.e_pend = e_pend; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(string name, int id, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got 0x%08h want 0x%08h", name, id, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, queue the expectation.
  task automatic drive(int id, vec_t v);
    exp_t e;
    rst = v.rst; stall_i = v.stall; branch_Or_Jump = v.sel; pc_plus4_id = v.p4;
    imm16_id = v.imm; index26_id = v.idx; rs_val_id = v.rs;
    e.id = id; e.pc = v.e_pc; e.flush = v.e_flush; e.pend = v.e_pend; e.err = v.e_err;
    sb.push_back(e);
  endtask

  // Sample on the falling edge and retire the oldest expectation.
  task automatic sample();
    exp_t e;
    @(negedge clk);
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard: empty queue at sample");
    end else begin
      e = sb.pop_front();
      chk("pc", e.id, pc, e.pc);
      chk("pc_plus4", e.id, pc_plus4, e.pc + 32'd4);
      chk("flush_if_id", e.id, {31'd0, flush_if_id}, {31'd0, e.flush});
      chk("redirect_pending", e.id, {31'd0, redirect_pending}, {31'd0, e.pend});
      chk("addr_err", e.id, {31'd0, addr_err}, {31'd0, e.err});
    end
  endtask

  task automatic step(int id, vec_t v);
    drive(id, v);
    sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] mis_pc;
    mis_pc = ALIGN ? 32'h0000_4180 : 32'h0000_3102;

    // Expected pc/flush/pending/addr_err are those visible during the row's own cycle.
    vecs.push_back(mk(1, 0, SEQ, 0, 0, 0, 0, 32'h3000, 0, 0, 0));
    vecs.push_back(mk(0, 0, SEQ, 0, 0, 0, 0, 32'h3000, 0, 0, 0));
    vecs.push_back(mk(0, 0, SEQ, 0, 0, 0, 0, 32'h3004, 0, 0, 0));
    vecs.push_back(mk(0, 0, SEQ, 0, 0, 0, 0, 32'h3008, 0, 0, 0));
    vecs.push_back(mk(0, 0, SEQ, 0, 0, 0, 0, 32'h300C, 0, 0, 0));
    vecs.push_back(mk(0, 0, BR, 32'h3010, 16'hFFFE, 0, 0, 32'h3010, 1, 0, 0));
    vecs.push_back(mk(0, 0, SEQ, 0, 0, 0, 0, 32'h3008, 0, 0, 0));
    vecs.push_back(mk(0, 0, JMP, 32'h3010, 0, 26'h0000C10, 0, 32'h300C, 1, 0, 0));
    vecs.push_back(mk(0, 0, SEQ, 0, 0, 0, 0, 32'h3040, 0, 0, 0));
    vecs.push_back(mk(0, 1, JR, 0, 0, 0, 32'h3100, 32'h3044, 0, 0, 0));
    vecs.push_back(mk(0, 1, JR, 0, 0, 0, 32'h3100, 32'h3044, 0, 1, 0));
    vecs.push_back(mk(0, 0, JR, 0, 0, 0, 32'h3100, 32'h3044, 1, 1, 0));
    vecs.push_back(mk(0, 0, SEQ, 0, 0, 0, 0, 32'h3100, 0, 0, 0));
    // Second redirect while one is buffered must be ignored; buffered branch wins on release.
    vecs.push_back(mk(0, 1, BR, 32'h3010, 16'hFFFE, 0, 0, 32'h3104, 0, 0, 0));
    vecs.push_back(mk(0, 1, JMP, 32'h3010, 0, 26'h0000C10, 0, 32'h3104, 0, 1, 0));
    vecs.push_back(mk(0, 0, JMP, 32'h3010, 0, 26'h0000C10, 0, 32'h3104, 1, 1, 0));
    vecs.push_back(mk(0, 0, SEQ, 0, 0, 0, 0, 32'h3008, 0, 0, 0));
    // Reset while a redirect is buffered.
    vecs.push_back(mk(0, 1, JR, 0, 0, 0, 32'h3100, 32'h300C, 0, 0, 0));
    vecs.push_back(mk(0, 1, SEQ, 0, 0, 0, 0, 32'h300C, 0, 1, 0));
    vecs.push_back(mk(1, 0, SEQ, 0, 0, 0, 0, 32'h300C, 0, 1, 0));
    vecs.push_back(mk(0, 0, SEQ, 0, 0, 0, 0, 32'h3000, 0, 0, 0));
    vecs.push_back(mk(0, 0, SEQ, 0, 0, 0, 0, 32'h3004, 0, 0, 0));
    // Misaligned JumpReg target.
    vecs.push_back(mk(0, 0, JR, 0, 0, 0, 32'h3102, 32'h3008, 1, 0, 0));
    vecs.push_back(mk(0, 0, SEQ, 0, 0, 0, 0, mis_pc, 0, 0, ALIGN));
    // Top-of-space target then sequential wrap to zero.
    vecs.push_back(mk(0, 0, JR, 0, 0, 0, 32'hFFFF_FFFC, mis_pc + 32'd4, 1, 0, 0));
    vecs.push_back(mk(0, 0, SEQ, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 0, 0));
    vecs.push_back(mk(0, 0, SEQ, 0, 0, 0, 0, 32'h0000_0000, 0, 0, 0));

    rst = 1'b1; stall_i = 1'b0; branch_Or_Jump = SEQ; pc_plus4_id = '0;
    imm16_id = '0; index26_id = '0; rs_val_id = '0;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) step(i, vecs[i]);

    // Hand sequence: a long stall with no redirect holds pc, then fetch resumes.
    step(100, mk(0, 1, SEQ, 0, 0, 0, 0, 32'h0000_0004, 0, 0, 0));
    step(101, mk(0, 1, SEQ, 0, 0, 0, 0, 32'h0000_0004, 0, 0, 0));
    step(102, mk(0, 1, SEQ, 0, 0, 0, 0, 32'h0000_0004, 0, 0, 0));
    step(103, mk(0, 0, SEQ, 0, 0, 0, 0, 32'h0000_0004, 0, 0, 0));
    step(104, mk(0, 0, SEQ, 0, 0, 0, 0, 32'h0000_0008, 0, 0, 0));

    // Hand sequence: misaligned target captured under stall is checked when it is applied.
    step(110, mk(0, 1, JR, 0, 0, 0, 32'h0000_5001, 32'h0000_000C, 0, 0, 0));
    step(111, mk(0, 0, SEQ, 0, 0, 0, 0, 32'h0000_000C, 1, 1, 0));
    step(112, mk(0, 0, SEQ, 0, 0, 0, 0, ALIGN ? 32'h0000_4180 : 32'h0000_5001, 0, 0, ALIGN));
    step(113, mk(0, 0, SEQ, 0, 0, 0, 0, ALIGN ? 32'h0000_4184 : 32'h0000_5005, 0, 0, 0));

    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard: %0d expectations left unretired", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
